elelock_prog: RTL and testbench



---
 rtl/elelock_prog.sv | 201 ++++++++++++++++++++
 tb/tb_elelock_prog.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elelock_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : elelock_prog                                               |
// | Description : Electronic lock controller with a reprogrammable PIN of    |
// |               DIGITS decimal digits. Synchronises and edge-detects a     |
// |               raw ten-key pad, buffers entered digits, compares them     |
// |               against the stored PIN and enforces a timed lockout with   |
// |               an alarm after MAX_FAIL consecutive wrong entries.         |
// | Ports       : ck       - clock, rising edge                              |
// |               reset    - asynchronous reset, active low                  |
// |               tenkey   - raw one-hot key pad, asynchronous to ck         |
// |               enter    - submit request, rising-edge qualified           |
// |               close    - lock request (level)                            |
// |               prog     - enter PIN-programming mode (level)              |
// |               lock     - door locked                                     |
// |               alarm    - lockout in progress                             |
// |               mode     - 0 OPEN, 1 LOCKED, 2 PROG, 3 LOCKOUT             |
// |               fail_cnt - consecutive failed attempts                     |
// |               dcount   - digits buffered, saturating at DIGITS           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module elelock_prog #(
  parameter int          DIGITS      = 4,
  parameter logic [31:0] DEFAULT_PIN = 32'h0000_5963,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 1024
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       enter,
  input  logic       close,
  input  logic       prog,
  output logic       lock,
  output logic       alarm,
  output logic [1:0] mode,
  output logic [3:0] fail_cnt,
  output logic [3:0] dcount
);

  localparam int                 c_buf_w     = 4 * DIGITS;
  localparam logic [1:0]         c_st_open   = 2'd0;
  localparam logic [1:0]         c_st_locked = 2'd1;
  localparam logic [1:0]         c_st_prog   = 2'd2;
  localparam logic [1:0]         c_st_lockout = 2'd3;
  localparam logic [c_buf_w-1:0] c_buf_clear = {c_buf_w{1'b1}};
  localparam logic [c_buf_w-1:0] c_pin_rst   = DEFAULT_PIN[c_buf_w-1:0];
  localparam logic [3:0]         c_digits    = 4'(DIGITS);
  localparam logic [3:0]         c_max_fail  = 4'(MAX_FAIL);
  localparam logic [15:0]        c_lock_load = 16'(LOCKOUT_CYC - 1);

  logic [9:0]         r_tk1;
  logic [9:0]         r_tk2;
  logic               r_enter_d;
  logic [c_buf_w-1:0] r_buf;
  logic [c_buf_w-1:0] r_pin;
  logic [3:0]         r_dcount;
  logic [1:0]         r_mode;
  logic               r_lock;
  logic               r_alarm;
  logic [3:0]         r_fail;
  logic [15:0]        r_timer;

  logic               w_press;
  logic               w_onehot;
  logic               w_take;
  logic               w_ev;
  logic               w_match;
  logic [3:0]         w_code;
  logic [c_buf_w-1:0] w_buf_shift;

  // A press is the first sampled cycle with any key down; multi-key chords
  // are dropped rather than guessed at.
  assign w_press  = (|r_tk1) & ~(|r_tk2);
  assign w_onehot = (r_tk1 != 10'd0) && ((r_tk1 & (r_tk1 - 10'd1)) == 10'd0);
  assign w_take   = w_press & w_onehot;
  assign w_ev     = enter & ~r_enter_d;
  assign w_match  = (r_dcount == c_digits) && (r_buf == r_pin);

  always_comb begin
    w_code = 4'd0;
    for (int n = 0; n < 10; n++) begin
      if (r_tk1[n]) w_code = 4'(n);
    end
  end

  // Newest digit enters at digit 0; the oldest falls off the top.
  generate
    if (DIGITS == 1) begin : g_single
      assign w_buf_shift = w_code;
    end else begin : g_multi
      assign w_buf_shift = {r_buf[c_buf_w-5:0], w_code};
    end
  endgenerate

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_tk1     <= 10'd0;
      r_tk2     <= 10'd0;
      r_enter_d <= 1'b0;
      r_buf     <= c_buf_clear;
      r_pin     <= c_pin_rst;
      r_dcount  <= 4'd0;
      r_mode    <= c_st_open;
      r_lock    <= 1'b0;
      r_alarm   <= 1'b0;
      r_fail    <= 4'd0;
      r_timer   <= 16'd0;
    end else begin
      r_tk1     <= tenkey;
      r_tk2     <= r_tk1;
      r_enter_d <= enter;

      case (r_mode)
        c_st_open: begin
          if (close) begin
            r_mode   <= c_st_locked;
            r_lock   <= 1'b1;
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
          end else if (prog) begin
            r_mode   <= c_st_prog;
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
          end else if (w_take) begin
            r_buf <= w_buf_shift;
            if (r_dcount != c_digits) r_dcount <= r_dcount + 4'd1;
          end
        end

        c_st_prog: begin
          if (close) begin
            r_mode   <= c_st_locked;
            r_lock   <= 1'b1;
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
          end else if (w_ev) begin
            // A short entry is discarded and programming continues.
            if (r_dcount == c_digits) begin
              r_pin  <= r_buf;
              r_mode <= c_st_open;
            end
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
          end else if (w_take) begin
            r_buf <= w_buf_shift;
            if (r_dcount != c_digits) r_dcount <= r_dcount + 4'd1;
          end
        end

        c_st_locked: begin
          if (close) begin
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
          end else if (w_ev) begin
            // Any press in this cycle is lost: the buffer is cleared.
            r_buf    <= c_buf_clear;
            r_dcount <= 4'd0;
            if (w_match) begin
              r_mode <= c_st_open;
              r_lock <= 1'b0;
              r_fail <= 4'd0;
            end else begin
              r_fail <= r_fail + 4'd1;
              if (r_fail + 4'd1 == c_max_fail) begin
                r_mode  <= c_st_lockout;
                r_alarm <= 1'b1;
                r_timer <= c_lock_load;
              end
            end
          end else if (w_take) begin
            r_buf <= w_buf_shift;
            if (r_dcount != c_digits) r_dcount <= r_dcount + 4'd1;
          end
        end

        default: begin
          // Lockout: all requests ignored; timer loaded with LOCKOUT_CYC-1
          // so the alarm spans exactly LOCKOUT_CYC edges.
          r_buf    <= c_buf_clear;
          r_dcount <= 4'd0;
          if (r_timer == 16'd0) begin
            r_mode  <= c_st_locked;
            r_alarm <= 1'b0;
            r_fail  <= 4'd0;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
      endcase
    end
  end

  assign lock     = r_lock;
  assign alarm    = r_alarm;
  assign mode     = r_mode;
  assign fail_cnt = r_fail;
  assign dcount   = r_dcount;

endmodule
`default_nettype wire

// File: tb/tb_elelock_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_elelock_prog                                            |
// | Description : Scoreboard bench for elelock_prog. Each stimulus cycle     |
// |               pushes the reference model's expected outputs; a monitor  |
// |               pops and compares them against the DUT.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_elelock_prog;

  localparam int          c_digits   = 4;
  localparam logic [31:0] c_def_pin  = 32'h0000_5963;
  localparam int          c_max_fail = 3;
  localparam int          c_lock_cyc = 8;

  logic       ck     = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] tenkey = 10'd0;
  logic       enter  = 1'b0;
  logic       close  = 1'b0;
  logic       prog   = 1'b0;
  logic       lock;
  logic       alarm;
  logic [1:0] mode;
  logic [3:0] fail_cnt;
  logic [3:0] dcount;

  elelock_prog #(
    .DIGITS     (c_digits),
    .DEFAULT_PIN(c_def_pin),
    .MAX_FAIL   (c_max_fail),
    .LOCKOUT_CYC(c_lock_cyc)
  ) dut (
    .ck      (ck),
    .reset   (reset),
    .tenkey  (tenkey),
    .enter   (enter),
    .close   (close),
    .prog    (prog),
    .lock    (lock),
    .alarm   (alarm),
    .mode    (mode),
    .fail_cnt(fail_cnt),
    .dcount  (dcount)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  // ---------------- reference model (lock behaviour in plain terms) -------
  logic [9:0] m_s1, m_s2;
  bit         m_en_prev;
  int         m_digits[$];   // entered digits, oldest first
  int         m_pin[$];      // stored PIN, in entry order
  int         m_mode, m_fails, m_remain;

  function automatic void m_reset();
    m_s1 = '0; m_s2 = '0; m_en_prev = 1'b0;
    m_digits.delete();
    m_pin.delete();
    for (int i = c_digits - 1; i >= 0; i--) m_pin.push_back(int'((c_def_pin >> (4 * i)) & 32'hF));
    m_mode = 0; m_fails = 0; m_remain = 0;
  endfunction

  function automatic bit m_match();
    if (m_digits.size() != c_digits) return 1'b0;
    for (int i = 0; i < c_digits; i++) if (m_digits[i] != m_pin[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_push(int d);
    m_digits.push_back(d);
    if (m_digits.size() > c_digits) void'(m_digits.pop_front());
  endfunction

  function automatic void m_edge(logic [9:0] tk, bit en, bit cl, bit pg);
    bit press, take, ev;
    int d;
    press = (m_s1 != 0) && (m_s2 == 0);
    take  = press && ($countones(m_s1) == 1);
    d = 0;
    for (int n = 0; n < 10; n++) if (m_s1[n]) d = n;
    ev = en && !m_en_prev;
    case (m_mode)
      0: begin
        if (cl) begin m_mode = 1; m_digits.delete(); end
        else if (pg) begin m_mode = 2; m_digits.delete(); end
        else if (take) m_push(d);
      end
      2: begin
        if (cl) begin m_mode = 1; m_digits.delete(); end
        else if (ev) begin
          if (m_digits.size() == c_digits) begin m_pin = m_digits; m_mode = 0; end
          m_digits.delete();
        end else if (take) m_push(d);
      end
      1: begin
        if (cl) m_digits.delete();
        else if (ev) begin
          if (m_match()) begin m_mode = 0; m_fails = 0; end
          else begin
            m_fails++;
            if (m_fails == c_max_fail) begin m_mode = 3; m_remain = c_lock_cyc; end
          end
          m_digits.delete();
        end else if (take) m_push(d);
      end
      default: begin
        m_digits.delete();
        m_remain--;
        if (m_remain == 0) begin m_mode = 1; m_fails = 0; end
      end
    endcase
    m_s2 = m_s1; m_s1 = tk; m_en_prev = en;
  endfunction

  function automatic logic [11:0] m_out();
    return {(m_mode == 1 || m_mode == 3), (m_mode == 3), 2'(m_mode), 4'(m_fails), 4'(m_digits.size())};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [11:0] val;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  string tag = "init";
  int    vectors = 0;
  int    miscompares = 0;
  event  chk_ev;

  function automatic void push_exp(int due);
    exp_t e;
    e.due = 32'(due);
    e.val = m_out();
    expq.push_back(e);
    tagq.push_back(tag);
  endfunction

  exp_t  mon_e;
  string mon_t;
  always @(negedge ck or chk_ev) begin
    while (expq.size() > 0 && int'(expq[0].due) <= cyc) begin
      mon_e = expq.pop_front();
      mon_t = tagq.pop_front();
      vectors++;
      if ({lock, alarm, mode, fail_cnt, dcount} !== mon_e.val) begin
        miscompares++;
        $display("FAIL %s cyc%0d: lock/alarm/mode/fail_cnt/dcount got %b/%b/%0d/%0d/%0d expected %b/%b/%0d/%0d/%0d",
                 mon_t, cyc, lock, alarm, mode, fail_cnt, dcount,
                 mon_e.val[11], mon_e.val[10], mon_e.val[9:8], mon_e.val[7:4], mon_e.val[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [9:0] tk, input bit en, input bit cl, input bit pg);
    tenkey = tk; enter = en; close = cl; prog = pg;
    m_edge(tk, en, cl, pg);
    push_exp(cyc + 1);
    @(posedge ck);
    #1;
  endtask

  task automatic key(input int d);
    tick(10'(1 << d), 1'b0, 1'b0, 1'b0);
    tick(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic keys(input int n, input logic [31:0] bcd);
    for (int i = n - 1; i >= 0; i--) key(int'((bcd >> (4 * i)) & 32'hF));
  endtask

  task automatic press_enter();
    tick(10'd0, 1'b1, 1'b0, 1'b0);
    tick(10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_close();
    tick(10'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Entered just after a posedge; reset asserts after the monitor's
  // negedge so the check happens with no clock edge in between.
  task automatic async_reset();
    #5;
    reset = 1'b0;
    tenkey = '0; enter = 1'b0; close = 1'b0; prog = 1'b0;
    m_reset();
    #1;
    push_exp(cyc);
    -> chk_ev;
    @(posedge ck);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] pin_bcd;
    int          r;
    logic [9:0]  tk;

    m_reset();
    #1 reset = 1'b0;
    #1;
    tag = "reset_state";
    push_exp(cyc);
    -> chk_ev;
    @(posedge ck);
    #1;
    reset = 1'b1;
    tick('0, 1'b0, 1'b0, 1'b0);

    tag = "basic_open";
    do_close();
    keys(4, 32'h5963);
    press_enter();

    tag = "short_entry";
    do_close();
    keys(3, 32'h596);
    press_enter();
    keys(4, 32'h5963);
    press_enter();

    tag = "lockout";
    do_close();
    repeat (3) begin
      keys(4, 32'h1111);
      press_enter();
    end
    keys(2, 32'h59);
    press_enter();
    tick('0, 1'b0, 1'b1, 1'b1);
    repeat (4) tick('0, 1'b0, 1'b0, 1'b0);
    keys(4, 32'h5963);
    press_enter();

    tag = "program";
    tick('0, 1'b0, 1'b0, 1'b1);
    keys(4, 32'h1234);
    press_enter();
    do_close();
    keys(4, 32'h5963);
    press_enter();
    keys(4, 32'h1234);
    press_enter();

    tag = "multikey_hold";
    do_close();
    tick(10'b00_1000_1000, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick(10'd16, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);

    tag = "enter_with_close";
    do_close();
    keys(4, 32'h1234);
    tick('0, 1'b1, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);

    tag = "enter_with_press";
    keys(3, 32'h123);
    tick(10'd16, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    keys(4, 32'h1234);
    press_enter();

    tag = "reset_lockout";
    do_close();
    repeat (3) begin
      keys(4, 32'h0000);
      press_enter();
    end
    tick('0, 1'b0, 1'b0, 1'b0);
    async_reset();
    do_close();
    keys(4, 32'h5963);
    press_enter();

    tag = "reset_prog";
    tick('0, 1'b0, 1'b0, 1'b1);
    keys(2, 32'h12);
    async_reset();
    do_close();
    keys(4, 32'h5963);
    press_enter();

    tag = "random";
    repeat (500) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        pin_bcd = '0;
        foreach (m_pin[i]) pin_bcd = (pin_bcd << 4) | 32'(m_pin[i]);
        keys(c_digits, pin_bcd);
        press_enter();
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 50)      tk = '0;
        else if (r < 85) tk = 10'(1 << $urandom_range(0, 9));
        else             tk = 10'($urandom_range(0, 1023));
        tick(tk, ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 14) == 0));
      end
    end

    tag = "drain";
    repeat (3) tick('0, 1'b0, 1'b0, 1'b0);
    @(negedge ck);
    #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
